// File: rtl/replay_pkg.sv
// Shared types and helpers for the link retransmit buffer.
package replay_pkg;

    // Transmit FSM: normal sending, or retransmitting after a rewind.
    typedef enum logic [0:0] {
        SEND   = 1'b0,
        REPLAY = 1'b1
    } state_e;

    // Pointer width: slot index plus one wrap bit to tell full from empty.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return int'($clog2(depth)) + 1;
    endfunction

endpackage

// File: rtl/replay_mem.sv
// Simple dual-port packet store: synchronous write, registered read, no reset.
module replay_mem #(
    parameter int unsigned WIDTH = 1024,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       re,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [WIDTH-1:0]           rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read; holds the last packet read when idle.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/replay_buffer.sv
// Retransmit buffer: sequence-numbered send, cumulative ACK free, NAK/timeout replay.
module replay_buffer
    import replay_pkg::*;
#(
    parameter int unsigned WIDTH      = 1024,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned SEQ_W      = 12,
    parameter int unsigned TIMEOUT    = 64,
    parameter int unsigned MAX_REPLAY = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       we,
    input  logic [WIDTH-1:0]           din,
    input  logic                       oe,
    input  logic                       ack,
    input  logic                       nak,
    input  logic [SEQ_W-1:0]           ack_seq,
    output logic [WIDTH-1:0]           dout,
    output logic                       dout_valid,
    output logic [SEQ_W-1:0]           dout_seq,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH)-1:0]   w_addr,
    output logic [$clog2(DEPTH)-1:0]   r_addr,
    output logic                       replaying,
    output logic                       replay_rollover
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = ptr_width(DEPTH);
    localparam int unsigned TW = $clog2(TIMEOUT);
    localparam int unsigned RW = $clog2(MAX_REPLAY + 1);

    localparam logic [0:0] ST_SEND   = SEND;
    localparam logic [0:0] ST_REPLAY = REPLAY;

    // Registered state
    logic [PW-1:0]    wr_q, rd_q, base_q, replay_end_q;
    logic [SEQ_W-1:0] next_seq_q, base_seq_q, dout_seq_q;
    logic [TW-1:0]    timer_q;
    logic [RW-1:0]    rcnt_q;
    logic [0:0]       state_q;
    logic             full_q, empty_q, dout_valid_q, rollover_q, dout_live_q;

    // Next-state values
    logic [PW-1:0]    wr_n, rd_n, base_n, replay_end_n, sent_cnt;
    logic [SEQ_W-1:0] next_seq_n, base_seq_n, seq_out_n, ack_off;
    logic [TW-1:0]    timer_n;
    logic [RW-1:0]    rcnt_n, cnt_base;
    logic [0:0]       state_n;
    logic             full_n, empty_n, rollover_n;
    logic             ack_valid, timeout, rewind, send, wr_en;

    logic [WIDTH-1:0] mem_rdata;

    replay_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_q[AW-1:0]),
        .wdata (din),
        .re    (send),
        .raddr (rd_q[AW-1:0]),
        .rdata (mem_rdata)
    );

    // Next-state: ACK/NAK resolution, pointers, timer, replay count and FSM.
    always_comb begin
        sent_cnt     = rd_q - base_q;
        ack_off      = ack_seq - base_seq_q;
        ack_valid    = (ack | nak) && (ack_off < SEQ_W'(sent_cnt));
        base_n       = base_q;
        base_seq_n   = base_seq_q;
        wr_n         = wr_q;
        next_seq_n   = next_seq_q;
        rd_n         = rd_q;
        timer_n      = timer_q;
        rcnt_n       = rcnt_q;
        cnt_base     = rcnt_q;
        rollover_n   = 1'b0;
        state_n      = state_q;
        replay_end_n = replay_end_q;
        seq_out_n    = base_seq_q + SEQ_W'(sent_cnt);

        // Cumulative acknowledge frees everything up to and including ack_seq.
        if (ack_valid) begin
            base_n     = base_q + PW'(ack_off) + PW'(1);
            base_seq_n = ack_seq + SEQ_W'(1);
        end

        timeout = (rd_q != base_q) && (timer_q == TW'(TIMEOUT - 1));
        rewind  = nak | timeout;
        send    = oe && !empty_q && !rewind;
        wr_en   = we && !full_q;

        if (wr_en) begin
            wr_n       = wr_q + PW'(1);
            next_seq_n = next_seq_q + SEQ_W'(1);
        end

        if (rewind) begin
            rd_n = base_n;
        end else if (send) begin
            rd_n = rd_q + PW'(1);
        end

        // Timer only runs while sent packets await acknowledgement.
        if (rewind || ack_valid) begin
            timer_n = '0;
        end else if (rd_q != base_q) begin
            timer_n = timer_q + TW'(1);
        end else begin
            timer_n = '0;
        end

        // ACK progress clears the count before this cycle's rewind is counted.
        if (ack_valid) begin
            cnt_base = '0;
        end
        rcnt_n = cnt_base;
        if (rewind) begin
            if (cnt_base + RW'(1) == RW'(MAX_REPLAY)) begin
                rcnt_n     = '0;
                rollover_n = 1'b1;
            end else begin
                rcnt_n = cnt_base + RW'(1);
            end
        end

        case (state_q)
            ST_SEND: begin
                if (rewind && (rd_q != base_n)) begin
                    state_n      = ST_REPLAY;
                    replay_end_n = rd_q;
                end
            end
            ST_REPLAY: begin
                if ((rd_n == replay_end_q) ||
                    (ack_valid && ((base_n - base_q) >= (replay_end_q - base_q)))) begin
                    state_n = ST_SEND;
                end
            end
            default: state_n = ST_SEND;
        endcase

        full_n  = (wr_n - base_n) == PW'(DEPTH);
        empty_n = (rd_n == wr_n);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_SEND;
        end else begin
            state_q <= state_n;
        end
    end

    // Pointers, sequence numbers, timer, replay count and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q         <= '0;
            rd_q         <= '0;
            base_q       <= '0;
            replay_end_q <= '0;
            next_seq_q   <= '0;
            base_seq_q   <= '0;
            timer_q      <= '0;
            rcnt_q       <= '0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            rollover_q   <= 1'b0;
        end else begin
            wr_q         <= wr_n;
            rd_q         <= rd_n;
            base_q       <= base_n;
            replay_end_q <= replay_end_n;
            next_seq_q   <= next_seq_n;
            base_seq_q   <= base_seq_n;
            timer_q      <= timer_n;
            rcnt_q       <= rcnt_n;
            full_q       <= full_n;
            empty_q      <= empty_n;
            rollover_q   <= rollover_n;
        end
    end

    // Transmit-side output registers; dout_live masks the unreset RAM read port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_valid_q <= 1'b0;
            dout_seq_q   <= '0;
            dout_live_q  <= 1'b0;
        end else begin
            dout_valid_q <= send;
            if (send) begin
                dout_seq_q  <= seq_out_n;
                dout_live_q <= 1'b1;
            end
        end
    end

    assign dout            = dout_live_q ? mem_rdata : '0;
    assign dout_valid      = dout_valid_q;
    assign dout_seq        = dout_seq_q;
    assign full            = full_q;
    assign empty           = empty_q;
    assign w_addr          = wr_q[AW-1:0];
    assign r_addr          = rd_q[AW-1:0];
    assign replaying       = (state_q == ST_REPLAY);
    assign replay_rollover = rollover_q;

endmodule
